// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite reader slice.
package sprite_pkg;
    localparam int               COORD_W = 12;
    localparam int               RGB_W   = 12;
    localparam logic [RGB_W-1:0] TRANSP  = 12'hF0F;

    typedef logic [RGB_W-1:0]   rgb_t;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read image ROM; contents are never reset.
module sprite_rom #(
    parameter int    DEPTH     = 12288,
    parameter int    DATA_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [DATA_W-1:0]        data_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) data_q <= mem[addr_i];

    assign data_o = data_q;
endmodule

// File: rtl/sprite_rom_reader.sv
// Multi-frame sprite lookup: pixel position -> ROM address -> colour/hit, fixed 2-cycle latency.
module sprite_rom_reader
    import sprite_pkg::*;
#(
    parameter int               IMG_W     = 48,
    parameter int               IMG_H     = 64,
    parameter int               FRAMES    = 4,
    parameter int               RGB_W     = sprite_pkg::RGB_W,
    parameter logic [RGB_W-1:0] TRANSP    = sprite_pkg::TRANSP,
    parameter string            INIT_FILE = "../../rtl/image_rom.data",
    localparam int              FSEL_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [FSEL_W-1:0] frame_sel,
    input  logic              mirror,
    input  coord_t            xpos,
    input  coord_t            ypos,
    input  logic              in_valid,
    input  coord_t            hcount,
    input  coord_t            vcount,
    output logic              out_valid,
    output logic [RGB_W-1:0]  rgb,
    output logic              hit
);
    localparam int DEPTH  = IMG_W * IMG_H * FRAMES;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [FSEL_W-1:0] frame_q, frame_d;
    logic              mirror_q;
    coord_t            xpos_q, ypos_q;

    logic [COORD_W:0]  dx, dy;
    coord_t            col;
    logic              inside_d;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [2:1]        vld_pipe_q, in_pipe_q;
    logic [RGB_W-1:0]  rom_data;

    // Out-of-range frame requests are clamped so the address never leaves the ROM.
    always_comb begin
        frame_d = frame_sel;
        if (int'(frame_sel) >= FRAMES) frame_d = FSEL_W'(FRAMES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q  <= '0;
            mirror_q <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= '0;
        end else if (frame_start) begin
            frame_q  <= frame_d;
            mirror_q <= mirror;
            xpos_q   <= xpos;
            ypos_q   <= ypos;
        end
    end

    // One extra bit makes the differences signed: hcount < xpos shows up as a set MSB.
    always_comb begin
        dx       = {1'b0, hcount} - {1'b0, xpos_q};
        dy       = {1'b0, vcount} - {1'b0, ypos_q};
        inside_d = in_valid
                 && !dx[COORD_W] && (dx[COORD_W-1:0] < COORD_W'(IMG_W))
                 && !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(IMG_H));
        col      = mirror_q ? (COORD_W'(IMG_W - 1) - dx[COORD_W-1:0]) : dx[COORD_W-1:0];
        addr_d   = '0;
        if (inside_d)
            addr_d = ADDR_W'(frame_q) * ADDR_W'(IMG_W * IMG_H)
                   + ADDR_W'(dy[COORD_W-1:0]) * ADDR_W'(IMG_W)
                   + ADDR_W'(col);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            vld_pipe_q <= '0;
            in_pipe_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            vld_pipe_q <= {vld_pipe_q[1], in_valid};
            in_pipe_q  <= {in_pipe_q[1], inside_d};
        end
    end

    sprite_rom #(
        .DEPTH    (DEPTH),
        .DATA_W   (RGB_W),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk   (clk),
        .addr_i(addr_q),
        .data_o(rom_data)
    );

    assign out_valid = vld_pipe_q[2];
    assign hit       = in_pipe_q[2] && (rom_data != TRANSP);
    assign rgb       = hit ? rom_data : '0;
endmodule

// File: tb/tb_sprite_rom_reader.sv
// Scoreboard bench: stimulus pushes model-predicted pixels, a negedge monitor pops and compares.
module tb_sprite_rom_reader;
    localparam int W  = 48;
    localparam int H  = 64;
    localparam int FR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [1:0]  frame_sel = '0;
    logic        mirror = 1'b0;
    logic [11:0] xpos = '0, ypos = '0, hcount = '0, vcount = '0;
    logic        in_valid = 1'b0;
    logic        out_valid, hit;
    logic [11:0] rgb;

    sprite_rom_reader #(
        .IMG_W(W), .IMG_H(H), .FRAMES(FR), .RGB_W(12), .TRANSP(12'hF0F), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_sel(frame_sel),
        .mirror(mirror), .xpos(xpos), .ypos(ypos), .in_valid(in_valid),
        .hcount(hcount), .vcount(vcount), .out_valid(out_valid), .rgb(rgb), .hit(hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hit;
        int          stamp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [11:0] rom_m [W*H*FR];
    int          checks = 0, errors = 0, cyc = 0, n_out = 0;
    int          m_fr = 0, m_x = 0, m_y = 0;
    bit          m_mir = 0;

    always @(posedge clk) cyc++;

    // Monitor: every valid output must match the oldest prediction, two cycles after issue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out rgb=%h hit=%b at cyc %0d", rgb, hit, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rgb !== mon_e.rgb || hit !== mon_e.hit || cyc - mon_e.stamp != 2) begin
                        errors++;
                        $display("FAIL pixel got rgb=%h hit=%b lat=%0d want rgb=%h hit=%b lat=2",
                                 rgb, hit, cyc - mon_e.stamp, mon_e.rgb, mon_e.hit);
                    end
                end
            end else begin
                checks++;
                if (rgb !== 12'h0 || hit !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_zero got rgb=%h hit=%b want 0/0", rgb, hit);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Reference: screen position relative to the active origin, looked up in the flat image array.
    task automatic drive(input bit iv, input int h, input int v, input bit fs,
                         input int fsel, input bit mir, input int x, input int y);
        exp_t e;
        int   dx, dy, w;
        in_valid = iv; hcount = 12'(h); vcount = 12'(v);
        frame_start = fs; frame_sel = 2'(fsel); mirror = mir; xpos = 12'(x); ypos = 12'(y);
        if (iv) begin
            dx = (h & 4095) - m_x;
            dy = (v & 4095) - m_y;
            e.hit = 1'b0; e.rgb = 12'h0; e.stamp = cyc;
            if (dx >= 0 && dx < W && dy >= 0 && dy < H) begin
                w = int'(rom_m[m_fr*W*H + dy*W + (m_mir ? W-1-dx : dx)]);
                if (w != 12'hF0F) begin e.hit = 1'b1; e.rgb = 12'(w); end
            end
            exp_q.push_back(e);
        end
        if (fs) begin
            m_fr = (fsel >= FR) ? FR-1 : fsel; m_mir = mir; m_x = x; m_y = y;
        end
        @(posedge clk); #1;
    endtask

    task automatic pix(input int h, input int v);
        drive(1, h, v, 0, 0, 0, 0, 0);
    endtask

    task automatic latch(input int fsel, input bit mir, input int x, input int y);
        drive(0, 0, 0, 1, fsel, mir, x, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n0, r, x;
        for (int i = 0; i < W*H*FR; i++)
            rom_m[i] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
        rom_m[0] = 12'h123; rom_m[W*H-1] = 12'hABC; rom_m[2*W*H+47] = 12'h456;
        rom_m[5] = 12'hF0F; rom_m[6] = 12'hF00; rom_m[2*W*H] = 12'h789;
        for (int i = 0; i < W*H*FR; i++) dut.u_rom.mem[i] = rom_m[i];

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_rgb", int'(rgb), 0);
        check("reset_hit", int'(hit), 0);
        rst = 1'b0;

        // Corners around origin (100,50), frame 0
        latch(0, 0, 100, 50);
        pix(100, 50); pix(147, 113); pix(148, 50); pix(99, 50); pix(147, 114); pix(100, 49);
        // Frame 2, mirrored
        latch(2, 1, 100, 50);
        pix(100, 50); pix(147, 50);
        // Shadow timing: same-cycle pixel sees the old origin
        drive(1, 100, 50, 1, 0, 0, 200, 50);
        pix(100, 50); pix(200, 50);
        pix(205, 50); pix(206, 50);
        // Clamp: frame_sel beyond FRAMES-1
        latch(3, 0, 200, 50);
        pix(200, 50); pix(247, 113);
        // Right-edge clipping near 4095
        latch(1, 0, 4070, 10);
        pix(4095, 10); pix(0, 10); pix(4069, 10);
        idle(3);

        // Back-to-back line of 640 pixels
        latch(0, 0, 20, 100);
        n0 = n_out;
        for (int h = 0; h < 640; h++) pix(h, 100 + (h % 64));
        idle(4);
        check("burst_out_count", n_out - n0, 640);

        // Randomised traffic with occasional shadow updates
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 57));
            if ($urandom_range(0, 40) == 0) begin
                x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4040, 4095))
                                                : int'($urandom_range(0, 700));
                drive($urandom_range(0, 1) == 1, (m_x + r - 5) & 4095,
                      (m_y + int'($urandom_range(0, 70)) - 3) & 4095,
                      1, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                      x, int'($urandom_range(0, 500)));
            end else begin
                drive($urandom_range(0, 3) != 0, (m_x + r - 5) & 4095,
                      (m_y + int'($urandom_range(0, 70)) - 3) & 4095, 0, 0, 0, 0, 0);
            end
        end
        idle(3);

        // Reset mid-stream: outputs clear at once, active state returns to defaults
        latch(2, 1, 300, 300);
        pix(300, 300); pix(301, 300); pix(302, 300);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_rgb", int'(rgb), 0);
        check("midrst_hit", int'(hit), 0);
        exp_q.delete();
        in_valid = 1'b0; frame_start = 1'b0;
        m_fr = 0; m_mir = 0; m_x = 0; m_y = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pix(0, 0); pix(47, 63); pix(48, 0);
        idle(4);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
